// File: rtl/mem_nr1w.sv
// Byte-masked 1-write / NREAD-read synchronous memory with write-first forwarding
// and a reset-time clear sequencer that fills every word with INIT_VAL.
module mem_nr1w #(
    parameter int unsigned     WIDTH    = 32,
    parameter int unsigned     WORD     = 1024,
    parameter int unsigned     NREAD    = 2,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   busy,
    input  logic [31:0]            waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   we,
    input  logic [WIDTH/8-1:0]     wbe,
    input  logic [NREAD-1:0]       re,
    input  logic [NREAD*32-1:0]    raddr,
    output logic [NREAD*WIDTH-1:0] rdata,
    output logic [NREAD-1:0]       rvalid
);

    localparam int unsigned AW = $clog2(WORD);
    localparam int unsigned NB = WIDTH / 8;

    typedef enum logic {StClear, StReady} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_next;
    logic            w_ready;

    logic [WIDTH-1:0] r_mem [WORD];

    logic             w_mem_we;
    logic [AW-1:0]    w_mem_addr;
    logic [WIDTH-1:0] w_mem_data;
    logic [NB-1:0]    w_mem_be;
    logic             w_unused_waddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StClear;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (r_state == StClear) begin
            w_cnt_next = r_cnt + 1'b1;
            if (r_cnt == AW'(WORD - 1)) begin
                w_state_next = StReady;
            end
        end
    end

    assign w_ready = (r_state == StReady);
    assign busy    = ~w_ready;

    // Clear writes and user writes share the single physical write port.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = waddr[AW-1:0];
        w_mem_data = wdata;
        w_mem_be   = wbe;
        if (!rst) begin
            if (r_state == StClear) begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_cnt;
                w_mem_data = INIT_VAL;
                w_mem_be   = '1;
            end else begin
                w_mem_we = we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int k = 0; k < NB; k++) begin
                if (w_mem_be[k]) begin
                    r_mem[w_mem_addr][8*k +: 8] <= w_mem_data[8*k +: 8];
                end
            end
        end
    end

    assign w_unused_waddr = ^waddr[31:AW];

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [AW-1:0]    w_ra;
        logic             w_hit;
        logic             w_unused_raddr;
        logic [WIDTH-1:0] r_raw;
        logic [WIDTH-1:0] r_fwd;
        logic [NB-1:0]    r_fmask;
        logic             r_valid;
        logic [WIDTH-1:0] w_rd;

        assign w_ra           = raddr[32*gi +: AW];
        assign w_unused_raddr = ^raddr[32*gi+AW +: 32-AW];
        assign w_hit          = w_ready & we & (w_ra == waddr[AW-1:0]);

        // Keep the array read a plain registered read (block-RAM friendly) and
        // apply write-first bypass bytes after the output register.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_raw   <= '0;
                r_fwd   <= '0;
                r_fmask <= '0;
                r_valid <= 1'b0;
            end else if (w_ready && re[gi]) begin
                r_raw   <= r_mem[w_ra];
                r_fwd   <= wdata;
                r_fmask <= w_hit ? wbe : '0;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end

        always_comb begin
            w_rd = r_raw;
            for (int k = 0; k < NB; k++) begin
                if (r_fmask[k]) begin
                    w_rd[8*k +: 8] = r_fwd[8*k +: 8];
                end
            end
        end

        assign rdata[WIDTH*gi +: WIDTH] = w_rd;
        assign rvalid[gi]               = r_valid;
    end

endmodule

// File: tb/tb_mem_nr1w.sv
// Randomised and directed bench for mem_nr1w (WORD=16, NREAD=2) against an
// array-based reference model of the memory, clear sequence and read ports.
module tb_mem_nr1w;

    localparam int          W  = 32;
    localparam int          D  = 16;
    localparam int          NR = 2;
    localparam logic [31:0] IV = 32'hDEADBEEF;

    logic            clk = 1'b0;
    logic            rst;
    logic            busy;
    logic [31:0]     waddr;
    logic [W-1:0]    wdata;
    logic            we;
    logic [W/8-1:0]  wbe;
    logic [NR-1:0]   re;
    logic [NR*32-1:0] raddr;
    logic [NR*W-1:0] rdata;
    logic [NR-1:0]   rvalid;

    mem_nr1w #(
        .WIDTH   (W),
        .WORD    (D),
        .NREAD   (NR),
        .INIT_VAL(IV)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .busy  (busy),
        .waddr (waddr),
        .wdata (wdata),
        .we    (we),
        .wbe   (wbe),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata),
        .rvalid(rvalid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_mem [D];
    logic [31:0] m_rd  [NR];
    logic [NR-1:0] m_rv = '0;
    bit          m_busy = 1'b1;
    int          m_left = D;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model by the same edge, then compare.
    task automatic step(input logic r, input logic w, input logic [31:0] wa,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [1:0] rv, input logic [31:0] ra0,
                        input logic [31:0] ra1);
        logic [31:0] ra [NR];
        logic [31:0] nw;
        rst   = r;
        we    = w;
        waddr = wa;
        wdata = wd;
        wbe   = be;
        re    = rv;
        raddr = {ra1, ra0};
        @(posedge clk);
        ra[0] = ra0;
        ra[1] = ra1;
        if (r) begin
            m_busy = 1'b1;
            m_left = D;
            m_rv   = '0;
            for (int i = 0; i < NR; i++) m_rd[i] = '0;
        end else if (m_busy) begin
            m_mem[D - m_left] = IV;
            m_left--;
            m_busy = (m_left != 0);
            m_rv   = '0;
        end else begin
            if (w) begin
                nw = m_mem[wa % D];
                for (int k = 0; k < 4; k++) if (be[k]) nw[8*k +: 8] = wd[8*k +: 8];
                m_mem[wa % D] = nw;
            end
            for (int i = 0; i < NR; i++) begin
                m_rv[i] = rv[i];
                if (rv[i]) m_rd[i] = m_mem[ra[i] % D];
            end
        end
        #1;
        check_eq("busy", {31'b0, busy}, {31'b0, m_busy});
        for (int i = 0; i < NR; i++) begin
            check_eq($sformatf("rvalid%0d", i), {31'b0, rvalid[i]}, {31'b0, m_rv[i]});
            check_eq($sformatf("rdata%0d", i), rdata[32*i +: 32], m_rd[i]);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 2'b00, 32'd0, 32'd0);
    endtask

    // Random accesses; during busy they must all be ignored.
    task automatic junk();
        step(1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom), 2'($urandom),
             $urandom, $urandom);
    endtask

    task automatic write(input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] be);
        step(1'b0, 1'b1, wa, wd, be, 2'b00, 32'd0, 32'd0);
    endtask

    task automatic read2(input logic [31:0] ra0, input logic [31:0] ra1);
        step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 2'b11, ra0, ra1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] hold_exp;

        // Clear sequence after a 3-cycle reset.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 0, 2'b00, 0, 0);
        check_eq("rst_rdata0", rdata[31:0], 32'h0);
        for (int i = 0; i < D; i++) begin
            junk();
            if (i == D - 2) check_eq("busy_edge15", {31'b0, busy}, 32'd1);
            if (i == D - 1) check_eq("busy_edge16", {31'b0, busy}, 32'd0);
        end
        for (int a = 0; a < D; a++) begin
            read2(a, a);
            check_eq("init_rd0", rdata[31:0], IV);
            check_eq("init_rd1", rdata[63:32], IV);
        end

        // Byte-masked write.
        write(5, 32'h11223344, 4'hF);
        write(5, 32'hAABBCCDD, 4'b0101);
        read2(5, 5);
        check_eq("byte_wr", rdata[31:0], 32'h11BB33DD);

        // Write-first forwarding on both ports.
        step(1'b0, 1'b1, 7, 32'hCAFEF00D, 4'hF, 2'b11, 7, 7);
        check_eq("fwd0", rdata[31:0], 32'hCAFEF00D);
        check_eq("fwd1", rdata[63:32], 32'hCAFEF00D);
        step(1'b0, 1'b1, 9, 32'h01020304, 4'b1001, 2'b11, 9, 32'h0000_0019);

        // Hold on port 0 while port 1 keeps reading.
        write(3, 32'h0BADCAFE, 4'hF);
        read2(3, 1);
        hold_exp = 32'h0BADCAFE;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 0, 0, 0, 2'b10, $urandom, i + 4);
            check_eq("hold_rdata0", rdata[31:0], hold_exp);
            check_eq("hold_rvalid0", {31'b0, rvalid[0]}, 32'd0);
        end

        // Mid-clear reset, then an ignored write during the restarted clear.
        step(1'b1, 1'b0, 0, 0, 0, 2'b00, 0, 0);
        for (int i = 0; i < 7; i++) junk();
        step(1'b1, 1'b0, 0, 0, 0, 2'b00, 0, 0);
        for (int i = 1; i <= D; i++) begin
            if (i == 4) write(2, 32'h5, 4'hF);
            else idle();
            if (i == D - 1) check_eq("reclr_busy15", {31'b0, busy}, 32'd1);
            if (i == D) check_eq("reclr_busy16", {31'b0, busy}, 32'd0);
        end
        read2(2, 32'h0000_0012);
        check_eq("busy_wr_ignored", rdata[31:0], IV);

        // Address aliasing modulo WORD.
        write(32'h0000_0013, 32'h12345678, 4'hF);
        read2(32'hFFFF_FFF3, 32'h0000_0003);
        check_eq("alias0", rdata[31:0], 32'h12345678);
        check_eq("alias1", rdata[63:32], 32'h12345678);

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 99) == 0), 1'($urandom), $urandom, $urandom,
                 4'($urandom), 2'($urandom), $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
